// File: rtl/video_line_scheduler_if.sv
// Renderer handshake between the line scheduler and the per-line renderer.
//   render_start  scheduler -> renderer  1-cycle request for render_line into render_buf
//   render_abort  scheduler -> renderer  1-cycle pulse: drop the render in progress
//   render_line   scheduler -> renderer  line index, held from request until done/abort
//   render_buf    scheduler -> renderer  target line buffer, held with render_line
//   render_done   renderer -> scheduler  1-cycle pulse: requested line is complete
interface video_line_scheduler_if;
  logic       render_start;
  logic       render_abort;
  logic [8:0] render_line;
  logic       render_buf;
  logic       render_done;

  modport master (
    output render_start,
    output render_abort,
    output render_line,
    output render_buf,
    input  render_done
  );

  modport slave (
    input  render_start,
    input  render_abort,
    input  render_line,
    input  render_buf,
    output render_done
  );
endinterface

// File: rtl/video_line_scheduler.sv
// Ping-pong line-buffer scheduler: requests line N+1 from the renderer while
// the readout drains line N, swaps buffers on every start_of_line, generates
// the readout address and recovers from late renders (underrun).
//   clk, rst              video clock, synchronous active-high reset
//   start_of_screen_i     frame start pulse
//   start_of_line_i       pulse on the last clock of every line
//   end_of_screen_i       pulse on the last clock of the last displayed line
//   next_pixel_i          advance readout address
//   underrun_clr_i        clear underrun_count_o
//   rnd                   renderer handshake (master side)
//   rd_buf_o, rd_addr_o   readout buffer select and pixel address
//   frame_active_o        high between start and end of screen
//   underrun_o            1-cycle pulse per detected underrun
//   underrun_count_o      saturating underrun counter
//
// state  | meaning
// IDLE   | no render outstanding
// RENDER | render_line outstanding (or its request is pending)
// READY  | render_line complete in render_buf
module video_line_scheduler #(
  parameter int PIXELS_PER_LINE = 640,
  parameter int NUM_LINES       = 240,
  parameter int ADDR_W          = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_of_screen_i,
  input  logic                   start_of_line_i,
  input  logic                   end_of_screen_i,
  input  logic                   next_pixel_i,
  input  logic                   underrun_clr_i,
  video_line_scheduler_if.master rnd,
  output logic                   rd_buf_o,
  output logic [ADDR_W-1:0]      rd_addr_o,
  output logic                   frame_active_o,
  output logic                   underrun_o,
  output logic [7:0]             underrun_count_o
);

  typedef enum logic [1:0] {IDLE, RENDER, READY} state_t;

  localparam logic [8:0]        LAST_LINE = 9'(NUM_LINES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(PIXELS_PER_LINE - 1);

  state_t            state_q;
  logic [8:0]        line_cnt_q;
  logic              wr_buf_q;
  logic              rd_buf_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              frame_active_q;
  logic              start_pend_q;
  logic              render_start_q;
  logic              render_abort_q;
  logic [8:0]        render_line_q;
  logic              render_buf_q;
  logic              underrun_q;
  logic [7:0]        underrun_count_q;

  logic sol_act;
  logic done_ok;
  logic underrun_evt;

  // start_of_line only counts when the frame is live and no higher-priority event is present.
  assign sol_act = start_of_line_i && frame_active_q && !start_of_screen_i && !end_of_screen_i;
  // A render_done arriving with start_of_line is on time; a pending (not yet issued)
  // request cannot be done.
  assign done_ok = (state_q == READY) ||
                   (state_q == RENDER && !start_pend_q && rnd.render_done);
  assign underrun_evt = sol_act && (state_q == RENDER) && !done_ok;

  // Whenever an abort is needed, the follow-up request is deferred one cycle through
  // start_pend_q so render_start and render_abort never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      line_cnt_q     <= '0;
      wr_buf_q       <= 1'b0;
      rd_buf_q       <= 1'b0;
      rd_addr_q      <= '0;
      frame_active_q <= 1'b0;
      start_pend_q   <= 1'b0;
      render_start_q <= 1'b0;
      render_abort_q <= 1'b0;
      render_line_q  <= '0;
      render_buf_q   <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      render_start_q <= 1'b0;
      render_abort_q <= 1'b0;
      underrun_q     <= 1'b0;

      if (start_of_screen_i) begin
        frame_active_q <= 1'b1;
        line_cnt_q     <= '0;
        wr_buf_q       <= 1'b0;
        state_q        <= RENDER;
        if (state_q == RENDER) begin
          render_abort_q <= 1'b1;
          start_pend_q   <= 1'b1;
        end else begin
          start_pend_q   <= 1'b0;
          render_start_q <= 1'b1;
          render_line_q  <= '0;
          render_buf_q   <= 1'b0;
        end
      end else if (end_of_screen_i) begin
        frame_active_q <= 1'b0;
        start_pend_q   <= 1'b0;
        state_q        <= IDLE;
        if (state_q == RENDER) render_abort_q <= 1'b1;
      end else if (sol_act && done_ok) begin
        rd_buf_q     <= wr_buf_q;
        wr_buf_q     <= ~wr_buf_q;
        start_pend_q <= 1'b0;
        if (line_cnt_q < LAST_LINE) begin
          line_cnt_q     <= line_cnt_q + 9'd1;
          render_start_q <= 1'b1;
          render_line_q  <= line_cnt_q + 9'd1;
          render_buf_q   <= ~wr_buf_q;
          state_q        <= RENDER;
        end else begin
          state_q <= IDLE;
        end
      end else if (underrun_evt) begin
        // Readout repeats the previous line; the late line is skipped.
        underrun_q     <= 1'b1;
        render_abort_q <= 1'b1;
        line_cnt_q     <= line_cnt_q + 9'd1;
        if (line_cnt_q < LAST_LINE) begin
          start_pend_q <= 1'b1;
        end else begin
          start_pend_q <= 1'b0;
          state_q      <= IDLE;
        end
      end else if (start_pend_q) begin
        start_pend_q   <= 1'b0;
        render_start_q <= 1'b1;
        render_line_q  <= line_cnt_q;
        render_buf_q   <= wr_buf_q;
      end else if (state_q == RENDER && rnd.render_done) begin
        state_q <= READY;
      end

      if (start_of_screen_i || sol_act) begin
        rd_addr_q <= '0;
      end else if (next_pixel_i && frame_active_q && rd_addr_q != ADDR_MAX) begin
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || underrun_clr_i) begin
      underrun_count_q <= '0;
    end else if (underrun_evt && underrun_count_q != 8'hFF) begin
      underrun_count_q <= underrun_count_q + 8'd1;
    end
  end

  assign rnd.render_start = render_start_q;
  assign rnd.render_abort = render_abort_q;
  assign rnd.render_line  = render_line_q;
  assign rnd.render_buf   = render_buf_q;
  assign rd_buf_o         = rd_buf_q;
  assign rd_addr_o        = rd_addr_q;
  assign frame_active_o   = frame_active_q;
  assign underrun_o       = underrun_q;
  assign underrun_count_o = underrun_count_q;

endmodule

// File: tb/tb_video_line_scheduler.sv
module tb_video_line_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       sos, sol, eos, npix, uclr;
  logic       rd_buf;
  logic [9:0] rd_addr;
  logic       frame_active;
  logic       underrun;
  logic [7:0] underrun_count;

  typedef struct {
    logic [8:0] line;
    logic       bsel;
  } req_t;

  req_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  video_line_scheduler_if rif();

  video_line_scheduler #(.PIXELS_PER_LINE(640), .NUM_LINES(240), .ADDR_W(10)) dut (
    .clk               (clk),
    .rst               (rst),
    .start_of_screen_i (sos),
    .start_of_line_i   (sol),
    .end_of_screen_i   (eos),
    .next_pixel_i      (npix),
    .underrun_clr_i    (uclr),
    .rnd               (rif.master),
    .rd_buf_o          (rd_buf),
    .rd_addr_o         (rd_addr),
    .frame_active_o    (frame_active),
    .underrun_o        (underrun),
    .underrun_count_o  (underrun_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every render_start must match the oldest expected request.
  always @(negedge clk) begin
    if (!rst) begin
      if (rif.render_start || rif.render_abort) begin
        n_checks++;
        if (rif.render_start && rif.render_abort) begin
          n_fail++;
          $display("FAIL start_abort_overlap: start=%0b abort=%0b required not both", rif.render_start, rif.render_abort);
        end
      end
      if (rif.render_start) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_start: line=%0d buf=%0b required no request", rif.render_line, rif.render_buf);
        end else begin
          req_t e;
          e = exp_q.pop_front();
          if (rif.render_line !== e.line || rif.render_buf !== e.bsel) begin
            n_fail++;
            $display("FAIL request: line=%0d buf=%0b required line=%0d buf=%0b", rif.render_line, rif.render_buf, e.line, e.bsel);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int line, input logic b);
    req_t r;
    r.line = 9'(line);
    r.bsel = b;
    exp_q.push_back(r);
  endtask

  task automatic pulse_sos();
    sos = 1'b1; cyc(); sos = 1'b0;
  endtask

  task automatic pulse_sol();
    sol = 1'b1; cyc(); sol = 1'b0;
  endtask

  task automatic pulse_done();
    rif.render_done = 1'b1; cyc(); rif.render_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sos = 0; sol = 0; eos = 0; npix = 0; uclr = 0; rif.render_done = 0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    n_checks++;
    if ({rif.render_start, rif.render_abort, rif.render_line, rif.render_buf, rd_buf, rd_addr,
         frame_active, underrun, underrun_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: start=%0b abort=%0b line=%0d buf=%0b rd_buf=%0b addr=%0d fa=%0b unr=%0b cnt=%0d required all 0",
               rif.render_start, rif.render_abort, rif.render_line, rif.render_buf, rd_buf, rd_addr,
               frame_active, underrun, underrun_count);
    end
  endtask

  task automatic test_start_of_screen();
    push(0, 1'b0);
    pulse_sos();
    n_checks++;
    if (rif.render_start !== 1'b1 || rif.render_line !== 9'd0 || rif.render_buf !== 1'b0 || frame_active !== 1'b1) begin
      n_fail++;
      $display("FAIL sos_first_request: start=%0b line=%0d buf=%0b fa=%0b required 1 0 0 1",
               rif.render_start, rif.render_line, rif.render_buf, frame_active);
    end
  endtask

  task automatic test_full_frame();
    for (int k = 0; k < 240; k++) begin
      repeat (100) cyc();
      pulse_done();
      repeat (3) cyc();
      if (k < 239) push(k + 1, 1'((k + 1) % 2));
      pulse_sol();
      n_checks++;
      if (rd_buf !== 1'(k % 2) || underrun !== 1'b0) begin
        n_fail++;
        $display("FAIL frame_swap line %0d: rd_buf=%0b underrun=%0b required rd_buf=%0b underrun=0", k, rd_buf, underrun, 1'(k % 2));
      end
    end
    repeat (5) cyc();
    n_checks++;
    if (underrun_count !== 8'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_end: count=%0d pending=%0d required 0 0", underrun_count, exp_q.size());
    end
  endtask

  task automatic test_underrun();
    push(0, 1'b0);
    pulse_sos();
    for (int k = 0; k < 5; k++) begin
      repeat (10) cyc();
      pulse_done();
      push(k + 1, 1'((k + 1) % 2));
      pulse_sol();
    end
    repeat (10) cyc();
    push(6, 1'b1);
    pulse_sol();
    n_checks++;
    if (underrun !== 1'b1 || rif.render_abort !== 1'b1 || rif.render_start !== 1'b0 || rd_buf !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_event: unr=%0b abort=%0b start=%0b rd_buf=%0b required 1 1 0 0",
               underrun, rif.render_abort, rif.render_start, rd_buf);
    end
    cyc();
    n_checks++;
    if (rif.render_start !== 1'b1 || underrun_count !== 8'd1) begin
      n_fail++;
      $display("FAIL underrun_restart: start=%0b count=%0d required 1 1", rif.render_start, underrun_count);
    end
  endtask

  task automatic test_rd_addr();
    npix = 1'b1; repeat (10) cyc(); npix = 1'b0;
    n_checks++;
    if (rd_addr !== 10'd10) begin
      n_fail++;
      $display("FAIL rd_addr_count: addr=%0d required 10", rd_addr);
    end
    npix = 1'b1; repeat (690) cyc(); npix = 1'b0;
    n_checks++;
    if (rd_addr !== 10'd639) begin
      n_fail++;
      $display("FAIL rd_addr_saturate: addr=%0d required 639", rd_addr);
    end
    pulse_done();
    push(7, 1'b0);
    npix = 1'b1; sol = 1'b1; cyc(); npix = 1'b0; sol = 1'b0;
    n_checks++;
    if (rd_addr !== 10'd0 || rd_buf !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_addr_sol_reset: addr=%0d rd_buf=%0b required 0 1", rd_addr, rd_buf);
    end
    npix = 1'b1; repeat (5) cyc(); npix = 1'b0;
  endtask

  task automatic test_end_of_screen();
    eos = 1'b1; sol = 1'b1; cyc(); eos = 1'b0; sol = 1'b0;
    n_checks++;
    if (rif.render_abort !== 1'b1 || frame_active !== 1'b0 || rd_buf !== 1'b1 || rif.render_start !== 1'b0) begin
      n_fail++;
      $display("FAIL eos_with_sol: abort=%0b fa=%0b rd_buf=%0b start=%0b required 1 0 1 0",
               rif.render_abort, frame_active, rd_buf, rif.render_start);
    end
    repeat (3) cyc();
    npix = 1'b1; cyc(); npix = 1'b0;
    pulse_sol();
    n_checks++;
    if (rd_buf !== 1'b1 || rd_addr !== 10'd5 || rif.render_start !== 1'b0 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL inactive_ignored: rd_buf=%0b addr=%0d start=%0b unr=%0b required 1 5 0 0",
               rd_buf, rd_addr, rif.render_start, underrun);
    end
  endtask

  task automatic test_restart();
    push(0, 1'b0);
    pulse_sos();
    repeat (4) cyc();
    push(0, 1'b0);
    pulse_sos();
    n_checks++;
    if (rif.render_abort !== 1'b1 || rif.render_start !== 1'b0 || frame_active !== 1'b1) begin
      n_fail++;
      $display("FAIL sos_in_render: abort=%0b start=%0b fa=%0b required 1 0 1", rif.render_abort, rif.render_start, frame_active);
    end
    cyc();
    n_checks++;
    if (rif.render_start !== 1'b1 || rif.render_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL sos_restart: start=%0b abort=%0b required 1 0", rif.render_start, rif.render_abort);
    end
    pulse_done();
    push(1, 1'b1);
    pulse_sol();
  endtask

  task automatic test_underrun_saturation();
    uclr = 1'b1; cyc(); uclr = 1'b0;
    push(0, 1'b0);
    pulse_sos();
    repeat (2) cyc();
    for (int i = 0; i < 240; i++) begin
      if (i < 239) push(i + 1, 1'b0);
      pulse_sol();
      cyc(); cyc();
    end
    n_checks++;
    if (underrun_count !== 8'd240 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL underrun_frame: count=%0d pending=%0d required 240 0", underrun_count, exp_q.size());
    end
    push(0, 1'b0);
    pulse_sos();
    cyc();
    for (int i = 0; i < 60; i++) begin
      push(i + 1, 1'b0);
      pulse_sol();
      cyc(); cyc();
    end
    n_checks++;
    if (underrun_count !== 8'd255) begin
      n_fail++;
      $display("FAIL underrun_saturate: count=%0d required 255", underrun_count);
    end
    push(61, 1'b0);
    uclr = 1'b1; sol = 1'b1; cyc(); uclr = 1'b0; sol = 1'b0;
    n_checks++;
    if (underrun !== 1'b1 || underrun_count !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_priority: unr=%0b count=%0d required 1 0", underrun, underrun_count);
    end
    cyc(); cyc();
    n_checks++;
    if (underrun_count !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_hold: count=%0d required 0", underrun_count);
    end
    eos = 1'b1; cyc(); eos = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if (exp_q.size() != 0 || frame_active !== 1'b0) begin
      n_fail++;
      $display("FAIL final_drain: pending=%0d fa=%0b required 0 0", exp_q.size(), frame_active);
    end
  endtask

  initial begin
    test_reset();
    test_start_of_screen();
    test_full_frame();
    test_underrun();
    test_rd_addr();
    test_end_of_screen();
    test_restart();
    test_underrun_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
